// File: rtl/bsg_wormhole_rr_merge.sv
// bsg_wormhole_rr_merge
//   N-input to 1-output wormhole merge: the per-output-port slice of a
//   wormhole router. Each input is buffered in a two-entry FIFO, a
//   round-robin arbiter picks a non-empty input and a one-hot mux drives
//   the output. A header flit with a non-zero length field locks the grant
//   to its input until that many body flits have been sent.
//
// Ports
//   clk_i    : clock, rising edge
//   reset_i  : asynchronous reset, active low
//   v_i      : per-input flit valid              [inputs_p]
//   data_i   : per-input flits, input k at [k*width_p +: width_p]
//   ready_o  : per-input ready (FIFO not full)   [inputs_p]
//   v_o      : output flit valid
//   data_o   : output flit                        [width_p]
//   tag_o    : binary index of granted input, 0 when v_o=0
//   ready_i  : downstream ready; transfer on v_o & ready_i
module bsg_wormhole_rr_merge #(
  parameter int unsigned inputs_p    = 4,
  parameter int unsigned width_p     = 16,
  parameter int unsigned len_width_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [inputs_p-1:0]           v_i,
  input  logic [inputs_p*width_p-1:0]   data_i,
  output logic [inputs_p-1:0]           ready_o,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  output logic [$clog2(inputs_p)-1:0]   tag_o,
  input  logic                          ready_i
);

  localparam int unsigned TagW = $clog2(inputs_p);

  // Input FIFO storage and bookkeeping
  logic [width_p-1:0]     r_mem   [inputs_p][2];
  logic [inputs_p-1:0]    r_rd_ptr;
  logic [inputs_p-1:0]    r_wr_ptr;
  logic [1:0]             r_count [inputs_p];

  // Arbiter state
  logic [TagW-1:0]        r_rr_ptr;
  logic [TagW-1:0]        r_lock;
  logic [len_width_p-1:0] r_len_cnt;

  logic [inputs_p-1:0]    w_nonempty;
  logic [inputs_p-1:0]    w_enq;
  logic [inputs_p-1:0]    w_deq;
  logic [width_p-1:0]     w_head [inputs_p];
  logic [inputs_p-1:0]    w_grant;
  logic [TagW-1:0]        w_gidx;
  logic [TagW-1:0]        w_scan;
  logic                   w_found;
  logic [width_p-1:0]     w_mux;
  logic                   w_xfer;

  // FIFO status, heads and handshakes
  always_comb begin
    for (int unsigned k = 0; k < inputs_p; k++) begin
      w_nonempty[k] = (r_count[k] != 2'd0);
      // gated by reset so ready_o reads 0 for the whole reset assertion
      ready_o[k]    = reset_i & (r_count[k] != 2'd2);
      w_enq[k]      = v_i[k] & ready_o[k];
      w_deq[k]      = w_grant[k] & ready_i;
      w_head[k]     = r_mem[k][r_rd_ptr[k]];
    end
  end

  // Grant: locked input only while a packet is in flight, otherwise the
  // first non-empty input scanning circularly from the pointer + 1.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_scan  = '0;
    w_found = 1'b0;
    if (r_len_cnt != '0) begin
      if (w_nonempty[r_lock]) begin
        w_grant[r_lock] = 1'b1;
        w_gidx          = r_lock;
      end
    end else begin
      for (int unsigned i = 0; i < inputs_p; i++) begin
        w_scan = TagW'((32'(r_rr_ptr) + 32'd1 + i) % inputs_p);
        if (!w_found && w_nonempty[w_scan]) begin
          w_found         = 1'b1;
          w_grant[w_scan] = 1'b1;
          w_gidx          = w_scan;
        end
      end
    end
  end

  // One-hot output mux; zero when nothing is granted
  always_comb begin
    w_mux = '0;
    for (int unsigned k = 0; k < inputs_p; k++) begin
      if (w_grant[k]) begin
        w_mux = w_mux | w_head[k];
      end
    end
  end

  assign v_o    = |w_grant;
  assign data_o = w_mux;
  assign tag_o  = w_gidx;
  assign w_xfer = v_o & ready_i;

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      for (int unsigned k = 0; k < inputs_p; k++) begin
        r_count[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < inputs_p; k++) begin
        if (w_enq[k]) r_wr_ptr[k] <= ~r_wr_ptr[k];
        if (w_deq[k]) r_rd_ptr[k] <= ~r_rd_ptr[k];
        r_count[k] <= r_count[k] + {1'b0, w_enq[k]} - {1'b0, w_deq[k]};
      end
    end
  end

  // FIFO storage needs no reset: occupancy guards every read
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < inputs_p; k++) begin
      if (w_enq[k]) begin
        r_mem[k][r_wr_ptr[k]] <= data_i[k*width_p +: width_p];
      end
    end
  end

  // Round-robin pointer, packet lock and body-flit counter
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rr_ptr  <= TagW'(inputs_p - 1);
      r_lock    <= '0;
      r_len_cnt <= '0;
    end else if (w_xfer) begin
      if (r_len_cnt == '0) begin
        r_rr_ptr  <= w_gidx;
        r_len_cnt <= w_mux[len_width_p-1:0];
        if (w_mux[len_width_p-1:0] != '0) begin
          r_lock <= w_gidx;
        end
      end else begin
        r_len_cnt <= r_len_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bsg_wormhole_rr_merge.sv
// Directed testbench for bsg_wormhole_rr_merge (4 inputs, 16-bit flits,
// 4-bit length field in the header's low nibble).
module tb_bsg_wormhole_rr_merge;

  localparam int unsigned NIn = 4;
  localparam int unsigned W   = 16;

  logic              clk;
  logic              reset_n;
  logic [NIn-1:0]    v_in;
  logic [NIn*W-1:0]  data_in;
  logic [NIn-1:0]    ready_out;
  logic              v_out;
  logic [W-1:0]      data_out;
  logic [1:0]        tag_out;
  logic              ready_in;

  int n_checks = 0;
  int n_errors = 0;

  bsg_wormhole_rr_merge #(
    .inputs_p   (NIn),
    .width_p    (W),
    .len_width_p(4)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_n),
    .v_i    (v_in),
    .data_i (data_in),
    .ready_o(ready_out),
    .v_o    (v_out),
    .data_o (data_out),
    .tag_o  (tag_out),
    .ready_i(ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int unsigned k, input logic [W-1:0] val);
    v_in[k] = 1'b1;
    data_in[k*W +: W] = val;
  endtask

  task automatic idle();
    v_in    = '0;
    data_in = '0;
  endtask

  task automatic out_is(input string name, input logic [1:0] tag, input logic [W-1:0] val);
    chk({name, ".v"},    32'(v_out),    32'd1);
    chk({name, ".tag"},  32'(tag_out),  32'(tag));
    chk({name, ".data"}, 32'(data_out), 32'(val));
  endtask

  task automatic out_none(input string name);
    chk({name, ".v"},    32'(v_out),    32'd0);
    chk({name, ".tag"},  32'(tag_out),  32'd0);
    chk({name, ".data"}, 32'(data_out), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    ready_in = 1'b0;
    idle();

    // ---- reset then idle ----
    #3;
    chk("rst.ready", 32'(ready_out), 32'h0);
    out_none("rst");
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("idle.ready", 32'(ready_out), 32'hF);
    out_none("idle");
    drv(2, 16'h00A0);
    step();
    idle();
    out_is("first", 2'd2, 16'h00A0);
    ready_in = 1'b1;
    step();
    out_none("first.drained");

    // ---- round-robin fairness (fresh reset: input 0 first) ----
    reset_n = 1'b0;
    #1;
    chk("rst2.ready", 32'(ready_out), 32'h0);
    step();
    reset_n = 1'b1;
    drv(0, 16'h0100);
    drv(1, 16'h0110);
    drv(3, 16'h0130);
    step();
    idle();
    out_is("rr0", 2'd0, 16'h0100);
    step();
    out_is("rr1", 2'd1, 16'h0110);
    step();
    out_is("rr3", 2'd3, 16'h0130);
    drv(0, 16'h0200);
    drv(1, 16'h0210);
    step();
    idle();
    out_is("rr0b", 2'd0, 16'h0200);
    step();
    out_is("rr1b", 2'd1, 16'h0210);
    step();
    out_none("rr.end");

    // ---- wormhole lock on input 1, len=2 ----
    drv(1, 16'h1102);
    step();
    drv(1, 16'h11BF);
    drv(0, 16'h0300);
    out_is("lk.hdr", 2'd1, 16'h1102);
    step();
    idle();
    drv(1, 16'h11BE);
    out_is("lk.b1", 2'd1, 16'h11BF);
    step();
    idle();
    out_is("lk.b2", 2'd1, 16'h11BE);
    step();
    out_is("lk.after", 2'd0, 16'h0300);
    step();
    out_none("lk.end");

    // ---- backpressure on input 0 ----
    ready_in = 1'b0;
    drv(0, 16'h4010);
    chk("bp.c0.ready0", 32'(ready_out[0]), 32'd1);
    step();
    chk("bp.c1.ready0", 32'(ready_out[0]), 32'd1);
    out_is("bp.c1", 2'd0, 16'h4010);
    drv(0, 16'h4020);
    step();
    chk("bp.c2.ready0", 32'(ready_out[0]), 32'd0);
    out_is("bp.c2", 2'd0, 16'h4010);
    drv(0, 16'h4030);
    step();
    chk("bp.c3.ready0", 32'(ready_out[0]), 32'd0);
    out_is("bp.c3", 2'd0, 16'h4010);
    step();
    chk("bp.c4.ready0", 32'(ready_out[0]), 32'd0);
    out_is("bp.c4", 2'd0, 16'h4010);
    step();
    ready_in = 1'b1;
    chk("bp.c5.ready0", 32'(ready_out[0]), 32'd0);
    out_is("bp.c5", 2'd0, 16'h4010);
    step();
    chk("bp.c6.ready0", 32'(ready_out[0]), 32'd1);
    out_is("bp.c6", 2'd0, 16'h4020);
    step();
    idle();
    out_is("bp.c7", 2'd0, 16'h4030);
    step();
    out_none("bp.end");

    // ---- locked input starved, input 3 must wait ----
    drv(2, 16'h2203);
    drv(3, 16'h3300);
    step();
    idle();
    drv(2, 16'h22B1);
    out_is("st.hdr", 2'd2, 16'h2203);
    step();
    idle();
    out_is("st.b1", 2'd2, 16'h22B1);
    step();
    out_none("st.gap1");
    step();
    out_none("st.gap2");
    drv(2, 16'h22B2);
    step();
    drv(2, 16'h22B3);
    out_is("st.b2", 2'd2, 16'h22B2);
    step();
    idle();
    out_is("st.b3", 2'd2, 16'h22B3);
    step();
    out_is("st.next", 2'd3, 16'h3300);
    step();
    out_none("st.end");

    // ---- async reset mid-packet ----
    drv(1, 16'h1505);
    step();
    drv(1, 16'h15B0);
    out_is("ar.hdr", 2'd1, 16'h1505);
    step();
    idle();
    out_is("ar.b1", 2'd1, 16'h15B0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar.ready", 32'(ready_out), 32'h0);
    out_none("ar.inrst");
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("ar.rel.ready", 32'(ready_out), 32'hF);
    out_none("ar.rel");
    drv(0, 16'h0500);
    step();
    idle();
    out_is("ar.new", 2'd0, 16'h0500);
    step();
    out_none("ar.end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
